quick_uart_rx_fifo: RTL

//  Parametrised UART receiver, successor to the single-register receiver. Adds configurable parity,

---
 rtl/quick_uart_rx_fifo.sv | 306 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/quick_uart_rx_fifo.sv
// quick_uart_rx_fifo: oversampling UART receiver with parity, multi-stop-bit checking,
// 3-sample majority voting, start-glitch rejection and a first-word-fall-through frame FIFO.
// Optional feature macro: QUICK_UART_RX_FIFO_BREAK_DETECT_EN adds break detection and the
// break_o port. Without it, a break is pushed as an ordinary frame with frame_err set.
module quick_uart_rx_fifo #(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DIV        = CLK_FREQ / BAUD,
  parameter logic        IDLE_VALUE = 1'b1,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 frame_err_o,
  output logic                 parity_err_o,
  output logic                 overrun_o
`ifdef QUICK_UART_RX_FIFO_BREAK_DETECT_EN
  ,
  output logic                 break_o
`endif
);

  localparam int unsigned CNT_W  = $clog2(DIV);
  localparam int unsigned BIT_W  = 4;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned OCC_W  = PTR_W + 1;
  localparam int unsigned ENT_W  = DATA_BITS + 2;

  // Elaboration-time parameter sanity checks
  generate
    if (DIV < 8) begin : g_bad_div
      $error("quick_uart_rx_fifo: DIV must be >= 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
      $error("quick_uart_rx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY > 2) begin : g_bad_par
      $error("quick_uart_rx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("quick_uart_rx_fifo: STOP_BITS must be 1 or 2");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("quick_uart_rx_fifo: DEPTH must be a power of two >= 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_PUSH,
    S_WAIT_IDLE
  } state_t;

  // Synchroniser and sample history
  logic rx_s1, rx_s2, rx_s3, rx_s4;
  logic maj_c;

  // Receiver state
  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] data_sh;
  logic                 par_bit;
  logic                 frame_err;
  logic                 last_bad;
  logic                 par_err_c;
  logic                 tick_c;
`ifdef QUICK_UART_RX_FIFO_BREAK_DETECT_EN
  logic                 all_active;
`endif

  // FIFO state
  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_nxt_c;
  logic [OCC_W-1:0] count, count_nxt_c;
  logic [ENT_W-1:0] head;
  logic [ENT_W-1:0] push_entry_c;
  logic             push_req_c, do_push_c, pop_c, full_c;

  // Two-flop synchroniser plus two history flops for the 3-sample vote
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_s1 <= IDLE_VALUE;
      rx_s2 <= IDLE_VALUE;
      rx_s3 <= IDLE_VALUE;
      rx_s4 <= IDLE_VALUE;
    end else begin
      rx_s1 <= rx_i;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
      rx_s4 <= rx_s3;
    end
  end

  // Majority of three consecutive synchronised samples around the bit centre
  always_comb begin
    maj_c  = (rx_s2 & rx_s3) | (rx_s2 & rx_s4) | (rx_s3 & rx_s4);
    tick_c = (cnt == '0);
  end

  // Parity check over the assembled data and the received parity bit
  always_comb begin
    par_err_c = 1'b0;
    if (PARITY == 1) begin
      par_err_c = ~(^data_sh ^ par_bit);
    end else if (PARITY == 2) begin
      par_err_c = ^data_sh ^ par_bit;
    end
  end

  // Receive FSM: bit timing, sampling and per-frame error collection
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      data_sh   <= '0;
      par_bit   <= 1'b0;
      frame_err <= 1'b0;
      last_bad  <= 1'b0;
`ifdef QUICK_UART_RX_FIFO_BREAK_DETECT_EN
      all_active <= 1'b0;
      break_o    <= 1'b0;
`endif
    end else begin
`ifdef QUICK_UART_RX_FIFO_BREAK_DETECT_EN
      break_o <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (rx_s2 != IDLE_VALUE) begin
            state <= S_START;
            cnt   <= CNT_W'(DIV / 2);
          end
        end
        S_START: begin
          if (tick_c) begin
            if (maj_c == IDLE_VALUE) begin
              state <= S_IDLE;
            end else begin
              state     <= S_DATA;
              cnt       <= CNT_W'(DIV - 1);
              bit_cnt   <= '0;
              frame_err <= 1'b0;
              last_bad  <= 1'b0;
              par_bit   <= 1'b0;
`ifdef QUICK_UART_RX_FIFO_BREAK_DETECT_EN
              all_active <= 1'b1;
`endif
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (tick_c) begin
            data_sh <= {maj_c, data_sh[DATA_BITS-1:1]};
            cnt     <= CNT_W'(DIV - 1);
`ifdef QUICK_UART_RX_FIFO_BREAK_DETECT_EN
            all_active <= all_active & (maj_c != IDLE_VALUE);
`endif
            if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_PARITY: begin
          if (tick_c) begin
            par_bit <= maj_c;
            cnt     <= CNT_W'(DIV - 1);
            bit_cnt <= '0;
            state   <= S_STOP;
`ifdef QUICK_UART_RX_FIFO_BREAK_DETECT_EN
            all_active <= all_active & (maj_c != IDLE_VALUE);
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_STOP: begin
          if (tick_c) begin
            if (maj_c != IDLE_VALUE) begin
              frame_err <= 1'b1;
            end
`ifdef QUICK_UART_RX_FIFO_BREAK_DETECT_EN
            all_active <= all_active & (maj_c != IDLE_VALUE);
`endif
            if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
              state    <= S_PUSH;
              last_bad <= (maj_c != IDLE_VALUE);
`ifdef QUICK_UART_RX_FIFO_BREAK_DETECT_EN
              // Pulse covers exactly the PUSH cycle
              break_o  <= all_active & (maj_c != IDLE_VALUE);
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              cnt     <= CNT_W'(DIV - 1);
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_PUSH: begin
          // A break always ends with a bad stop bit, so it lands in WAIT_IDLE too
          state <= last_bad ? S_WAIT_IDLE : S_IDLE;
        end
        S_WAIT_IDLE: begin
          if (rx_s2 == IDLE_VALUE) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // FIFO push/pop decisions and next occupancy
  always_comb begin
    push_entry_c = {par_err_c, frame_err, data_sh};
`ifdef QUICK_UART_RX_FIFO_BREAK_DETECT_EN
    push_req_c   = (state == S_PUSH) && !break_o;
`else
    push_req_c   = (state == S_PUSH);
`endif
    pop_c        = valid_o && ready_i;
    full_c       = (count == OCC_W'(DEPTH));
    do_push_c    = push_req_c && (!full_c || pop_c);
    rd_nxt_c     = rd_ptr + PTR_W'(1);
    count_nxt_c  = count;
    if (do_push_c && !pop_c) begin
      count_nxt_c = count + 1'b1;
    end else if (!do_push_c && pop_c) begin
      count_nxt_c = count - 1'b1;
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read
  always_ff @(posedge clk_i) begin
    if (do_push_c) begin
      mem[wr_ptr] <= push_entry_c;
    end
  end

  // FIFO pointers, occupancy, registered head entry and overrun flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      valid_o   <= 1'b0;
      head      <= '0;
      overrun_o <= 1'b0;
    end else begin
      count   <= count_nxt_c;
      valid_o <= (count_nxt_c != '0);
      if (do_push_c) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_c) begin
        rd_ptr <= rd_nxt_c;
      end
      if (pop_c) begin
        if (count == OCC_W'(1)) begin
          if (do_push_c) begin
            head <= push_entry_c;
          end
        end else begin
          head <= mem[rd_nxt_c];
        end
      end else if (do_push_c && count == '0) begin
        head <= push_entry_c;
      end
      if (pop_c) begin
        overrun_o <= 1'b0;
      end else if (push_req_c && !do_push_c) begin
        overrun_o <= 1'b1;
      end
    end
  end

  // Head entry fields
  always_comb begin
    data_o       = head[DATA_BITS-1:0];
    frame_err_o  = head[DATA_BITS];
    parity_err_o = head[DATA_BITS+1];
  end

endmodule
